// File: rtl/receiver.sv
// Serial receiver: resynchronizes the line, reassembles 11-bit frames into bytes
// and offers each byte to the consumer over a 4-phase req/ack handshake.
module receiver #(
    parameter int CLKS_PER_BIT = 5220
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       rcv,
    input  logic       ack,
    output logic [7:0] data,
    output logic       req,
    output logic       ferr,
    output logic       ovr
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] MID  = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP1, STOP2, WAIT_HIGH} rx_state_t;
    typedef enum logic [1:0] {HS_IDLE, HS_REQ, HS_DROP} hs_state_t;

    logic            sync1;
    logic            rs;
    rx_state_t       state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [2:0]      idx, idx_nxt;
    logic [7:0]      shreg, shreg_nxt;
    logic            stop1_ok, stop1_ok_nxt;
    hs_state_t       hs, hs_nxt;
    logic [7:0]      data_nxt;
    logic            req_nxt;
    logic            ferr_nxt;
    logic            ovr_nxt;
    logic            frame_good;
    logic            frame_bad;

    always_ff @(posedge clk) begin
        if (clr) begin
            sync1    <= 1'b1;
            rs       <= 1'b1;
            state    <= IDLE;
            cnt      <= '0;
            idx      <= '0;
            shreg    <= '0;
            stop1_ok <= 1'b0;
            hs       <= HS_IDLE;
            data     <= '0;
            req      <= 1'b0;
            ferr     <= 1'b0;
            ovr      <= 1'b0;
        end else begin
            sync1    <= rcv;
            rs       <= sync1;
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            idx      <= idx_nxt;
            shreg    <= shreg_nxt;
            stop1_ok <= stop1_ok_nxt;
            hs       <= hs_nxt;
            data     <= data_nxt;
            req      <= req_nxt;
            ferr     <= ferr_nxt;
            ovr      <= ovr_nxt;
        end
    end

    // Counter is compared against N-1 because it starts at 0 on the cycle after entry.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt + 1'b1;
        idx_nxt      = idx;
        shreg_nxt    = shreg;
        stop1_ok_nxt = stop1_ok;
        frame_good   = 1'b0;
        frame_bad    = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (!rs) state_nxt = START;
            end
            START: begin
                if (cnt == MID) begin
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                    state_nxt = rs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == LAST) begin
                    cnt_nxt   = '0;
                    shreg_nxt = {rs, shreg[7:1]};
                    idx_nxt   = idx + 1'b1;
                    if (idx == 3'd7) state_nxt = STOP1;
                end
            end
            STOP1: begin
                if (cnt == LAST) begin
                    cnt_nxt      = '0;
                    stop1_ok_nxt = rs;
                    state_nxt    = STOP2;
                end
            end
            STOP2: begin
                if (cnt == LAST) begin
                    cnt_nxt = '0;
                    if (stop1_ok && rs) begin
                        frame_good = 1'b1;
                        state_nxt  = IDLE;
                    end else begin
                        frame_bad = 1'b1;
                        state_nxt = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                cnt_nxt = '0;
                if (rs) state_nxt = IDLE;
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    // Slot 8 carries bit 0, so the last sample shifted in is rotated to the LSB.
    always_comb begin
        hs_nxt   = hs;
        data_nxt = data;
        req_nxt  = req;
        ferr_nxt = frame_bad;
        ovr_nxt  = 1'b0;
        case (hs)
            HS_IDLE: begin
                if (frame_good) begin
                    data_nxt = {shreg[6:0], shreg[7]};
                    req_nxt  = 1'b1;
                    hs_nxt   = HS_REQ;
                end
            end
            HS_REQ: begin
                if (ack) begin
                    req_nxt = 1'b0;
                    hs_nxt  = HS_DROP;
                end
            end
            HS_DROP: begin
                if (!ack) hs_nxt = HS_IDLE;
            end
            default: begin
                req_nxt = 1'b0;
                hs_nxt  = HS_IDLE;
            end
        endcase
        if (frame_good && hs != HS_IDLE) ovr_nxt = 1'b1;
    end

endmodule

// File: tb/tb_receiver.sv
// Randomized scoreboard bench for receiver: frames are predicted from the line
// format, and a monitor matches every req/ferr/ovr event against the queues.
module tb_receiver;

    localparam int CPB = 16;
    localparam int LAT = 3 + CPB / 2 + 10 * CPB;
    localparam int INF = 32'h7fffffff;

    logic       clk = 1'b0;
    logic       clr;
    logic       rcv;
    logic       ack;
    logic [7:0] data;
    logic       req;
    logic       ferr;
    logic       ovr;

    receiver #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .clr(clr), .rcv(rcv), .ack(ack),
        .data(data), .req(req), .ferr(ferr), .ovr(ovr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] b;
        int         due;
    } exp_t;

    exp_t byte_q[$];
    int   ferr_q[$];
    int   ovr_q[$];
    int   checks = 0;
    int   errors = 0;
    int   pending_until = 0;
    bit   hold = 1'b0;
    bit   mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Reference model: a frame that starts on the line at cycle 'start' resolves
    // LAT cycles later into a byte, an overrun or a framing error.
    task automatic expect_frame(input logic [7:0] b, input bit s1, input bit s2, input int start);
        int due;
        due = start + LAT;
        if (!(s1 && s2)) ferr_q.push_back(due);
        else if (due < pending_until) ovr_q.push_back(due);
        else begin
            byte_q.push_back('{b, due});
            pending_until = hold ? INF : due + 40;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit s1, input bit s2);
        logic line [11];
        line[0] = 1'b0;
        for (int k = 1; k < 8; k++) line[k] = b[k];
        line[8]  = b[0];
        line[9]  = s1;
        line[10] = s2;
        expect_frame(b, s1, s2, cyc);
        for (int i = 0; i < 11; i++) begin
            rcv = line[i];
            idle(CPB);
        end
    endtask

    // Monitor
    initial begin
        logic       prev_req;
        logic [7:0] held;
        exp_t       e;
        int         due;
        prev_req = 1'b0;
        held     = '0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (req === 1'b1 && prev_req) check("data_stable", data, held);
                if (req !== 1'b0 && !prev_req) begin
                    if (byte_q.size() == 0) check("req_unexpected", req, 0);
                    else begin
                        e = byte_q.pop_front();
                        check("data", data, e.b);
                        check("req_cycle", cyc, e.due);
                    end
                    held = data;
                end
                if (ferr !== 1'b0) begin
                    if (ferr_q.size() == 0) check("ferr_unexpected", ferr, 0);
                    else begin
                        due = ferr_q.pop_front();
                        check("ferr_cycle", cyc, due);
                    end
                end
                if (ovr !== 1'b0) begin
                    if (ovr_q.size() == 0) check("ovr_unexpected", ovr, 0);
                    else begin
                        due = ovr_q.pop_front();
                        check("ovr_cycle", cyc, due);
                    end
                end
                prev_req = (req === 1'b1);
            end
        end
    end

    // Consumer: ack 10 cycles after req, drop 3 cycles after req falls
    initial begin
        ack = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en && req === 1'b1 && !hold) begin
                repeat (10) @(posedge clk);
                #1 ack = 1'b1;
                @(negedge clk);
                check("req_until_ack_seen", req, 1);
                @(negedge clk);
                check("req_fall_after_ack", req, 0);
                repeat (3) @(posedge clk);
                #1 ack = 1'b0;
            end
        end
    end

    initial begin
        #(200000 * 10);
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        int   kind;
        bit   s1;
        bit   s2;
        logic [7:0] b;

        clr = 1'b1;
        rcv = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("reset_data", data, 0);
        check("reset_req", req, 0);
        check("reset_ferr", ferr, 0);
        check("reset_ovr", ovr, 0);
        @(posedge clk); #1;
        clr    = 1'b0;
        mon_en = 1'b1;
        idle(5);

        // good frame
        send_frame(8'hA5, 1'b1, 1'b1);
        idle(40);

        // false start then a clean frame
        rcv = 1'b0;
        idle(4);
        rcv = 1'b1;
        idle(2 * CPB);
        send_frame(8'h3C, 1'b1, 1'b1);
        idle(40);

        // framing error with line held low afterwards
        send_frame(8'h55, 1'b0, 1'b0);
        idle(100);
        rcv = 1'b1;
        idle(CPB);
        send_frame(8'h81, 1'b1, 1'b1);
        idle(40);

        // overrun
        hold = 1'b1;
        send_frame(8'h12, 1'b1, 1'b1);
        send_frame(8'h34, 1'b1, 1'b1);
        check("ovr_keeps_req", req, 1);
        check("ovr_keeps_data", data, 8'h12);
        hold = 1'b0;
        idle(40);
        pending_until = 0;
        send_frame(8'h56, 1'b1, 1'b1);
        idle(40);

        // reset during data slot 4 of 0xFF
        rcv = 1'b0;
        idle(CPB);
        rcv = 1'b1;
        idle(3 * CPB + CPB / 2);
        clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        check("midreset_data", data, 0);
        check("midreset_req", req, 0);
        check("midreset_ferr", ferr, 0);
        check("midreset_ovr", ovr, 0);
        pending_until = 0;
        @(posedge clk); #1;
        idle(8 * CPB);
        send_frame(8'h3C, 1'b1, 1'b1);
        idle(40);

        // zero-gap stream
        send_frame(8'h01, 1'b1, 1'b1);
        send_frame(8'h80, 1'b1, 1'b1);
        send_frame(8'hFE, 1'b1, 1'b1);
        idle(40);

        // randomized frames, errors, false starts and gaps
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                rcv = 1'b0;
                idle($urandom_range(1, CPB / 2 - 2));
                rcv = 1'b1;
                idle(CPB);
            end
            b    = 8'($urandom);
            kind = $urandom_range(0, 9);
            s1   = (kind != 0);
            s2   = (kind != 1);
            send_frame(b, s1, s2);
            rcv = 1'b1;
            if (!(s1 && s2)) idle(CPB + $urandom_range(0, 10));
            else idle($urandom_range(0, 20));
        end

        idle(LAT + 50);
        check("bytes_outstanding", byte_q.size(), 0);
        check("ferr_outstanding", ferr_q.size(), 0);
        check("ovr_outstanding", ovr_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
